// File: rtl/perf_pkg.sv
// Shared definitions for the performance monitor: ALU op-code map, default power
// weights and a small saturation helper.
package perf_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9
    } alu_op_e;

    localparam int unsigned DEF_ALU_WEIGHT = 2;
    localparam int unsigned DEF_PWR_SHIFT  = 2;
    localparam int unsigned DEF_PWR_WINDOW = 64;

    function automatic logic [7:0] sat8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/perf_argmax_scan.sv
// Round-robin argmax scanner: visits one register/op bin pair per cycle and
// publishes the lowest index holding the strict maximum at the end of each sweep.
module perf_argmax_scan
    import perf_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_OPS  = 16,
    parameter int unsigned HIST_W   = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic [HIST_W-1:0]           reg_val_i,
    input  logic [HIST_W-1:0]           op_val_i,
    output logic [$clog2(NUM_REGS)-1:0] idx_o,
    output logic [$clog2(NUM_REGS)-1:0] best_reg_o,
    output logic [$clog2(NUM_OPS)-1:0]  best_op_o
);
    localparam int unsigned RW = $clog2(NUM_REGS);
    localparam int unsigned OW = $clog2(NUM_OPS);

    logic [RW-1:0]     idx_q, idx_d;
    logic [HIST_W-1:0] max_reg_q, max_reg_d, max_op_q, max_op_d;
    logic [RW-1:0]     cand_reg_q, cand_reg_d, pub_reg_q, pub_reg_d;
    logic [OW-1:0]     cand_op_q, cand_op_d, pub_op_q, pub_op_d;
    logic              reg_wins, op_wins;

    always_comb begin
        reg_wins   = reg_val_i > max_reg_q;
        op_wins    = (32'(idx_q) < NUM_OPS) && (op_val_i > max_op_q);
        idx_d      = idx_q + RW'(1);
        max_reg_d  = reg_wins ? reg_val_i : max_reg_q;
        cand_reg_d = reg_wins ? idx_q : cand_reg_q;
        max_op_d   = op_wins ? op_val_i : max_op_q;
        cand_op_d  = op_wins ? idx_q[OW-1:0] : cand_op_q;
        pub_reg_d  = pub_reg_q;
        pub_op_d   = pub_op_q;
        // Final bin folds into the published result; the next sweep starts from zero.
        if (idx_q == RW'(NUM_REGS - 1)) begin
            pub_reg_d  = cand_reg_d;
            pub_op_d   = cand_op_d;
            max_reg_d  = '0;
            cand_reg_d = '0;
            max_op_d   = '0;
            cand_op_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni || clear_i) begin
            idx_q      <= '0;
            max_reg_q  <= '0;
            cand_reg_q <= '0;
            max_op_q   <= '0;
            cand_op_q  <= '0;
            pub_reg_q  <= '0;
            pub_op_q   <= '0;
        end else begin
            idx_q      <= idx_d;
            max_reg_q  <= max_reg_d;
            cand_reg_q <= cand_reg_d;
            max_op_q   <= max_op_d;
            cand_op_q  <= cand_op_d;
            pub_reg_q  <= pub_reg_d;
            pub_op_q   <= pub_op_d;
        end
    end

    assign idx_o      = idx_q;
    assign best_reg_o = pub_reg_q;
    assign best_op_o  = pub_op_q;

endmodule

// File: rtl/perf_monitor.sv
// Retired-instruction performance monitor: wrapping totals, saturating usage
// histograms with published argmax, and a windowed power estimate.
module perf_monitor
    import perf_pkg::*;
#(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned NUM_OPS    = 16,
    parameter int unsigned HIST_W     = 16,
    parameter int unsigned PWR_WINDOW = DEF_PWR_WINDOW,
    parameter int unsigned PWR_SHIFT  = DEF_PWR_SHIFT,
    parameter int unsigned ALU_WEIGHT = DEF_ALU_WEIGHT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        evtValid,
    input  logic                        evtIsAlu,
    input  logic                        evtUsesRs2,
    input  logic                        evtRegWrite,
    input  logic [$clog2(NUM_OPS)-1:0]  evtOp,
    input  logic [$clog2(NUM_REGS)-1:0] evtRs1,
    input  logic [$clog2(NUM_REGS)-1:0] evtRs2,
    input  logic [$clog2(NUM_REGS)-1:0] evtRd,
    input  logic                        clear,
    input  logic                        freeze,
    output logic [CNT_W-1:0]            totalInstructions,
    output logic [CNT_W-1:0]            totalOperationsALU,
    output logic [CNT_W-1:0]            totalRegAccesses,
    output logic [$clog2(NUM_REGS)-1:0] mostUsedReg,
    output logic [$clog2(NUM_OPS)-1:0]  mostUsedOpsALU,
    output logic [7:0]                  currentEstimatedPower,
    output logic                        counterOverflow
);
    localparam int unsigned RW = $clog2(NUM_REGS);
    localparam int unsigned OW = $clog2(NUM_OPS);
    localparam int unsigned WW = $clog2(PWR_WINDOW + 1);
    localparam logic [HIST_W+1:0] HMAX = {2'b00, {HIST_W{1'b1}}};

    logic              accept;
    logic [1:0]        accesses;
    logic [CNT_W-1:0]  instr_q, alu_q, racc_q;
    logic [CNT_W:0]    instr_d, alu_d, racc_d;
    logic              ovf_q, wrap;
    logic [HIST_W-1:0] reg_bin_q [NUM_REGS];
    logic [HIST_W-1:0] reg_bin_d [NUM_REGS];
    logic [HIST_W-1:0] op_bin_q  [NUM_OPS];
    logic [HIST_W-1:0] op_bin_d  [NUM_OPS];
    logic [WW-1:0]     win_q, win_d;
    logic [31:0]       pacc_q, pacc_d, pacc_sum;
    logic [7:0]        pwr_q, pwr_d;
    logic              win_end;
    logic [RW-1:0]     scan_idx;

    always_comb begin
        accept   = evtValid & ~freeze & ~clear;
        accesses = accept ? (2'd1 + 2'(evtUsesRs2) + 2'(evtRegWrite)) : 2'd0;
        // Extra MSB captures the carry out so a wrap can be flagged.
        instr_d  = {1'b0, instr_q} + (CNT_W+1)'(accept);
        alu_d    = {1'b0, alu_q} + (CNT_W+1)'(accept & evtIsAlu);
        racc_d   = {1'b0, racc_q} + (CNT_W+1)'(accesses);
        wrap     = instr_d[CNT_W] | alu_d[CNT_W] | racc_d[CNT_W];
    end

    always_comb begin
        logic [1:0]        hits;
        logic [HIST_W+1:0] s;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            hits = accept ? (2'(evtRs1 == RW'(k))
                           + 2'(evtUsesRs2 && (evtRs2 == RW'(k)))
                           + 2'(evtRegWrite && (evtRd == RW'(k)))) : 2'd0;
            s = {2'b00, reg_bin_q[k]} + (HIST_W+2)'(hits);
            reg_bin_d[k] = (s > HMAX) ? '1 : s[HIST_W-1:0];
        end
        for (int unsigned k = 0; k < NUM_OPS; k++) begin
            op_bin_d[k] = op_bin_q[k];
            if (accept && evtIsAlu && (evtOp == OW'(k)) && (op_bin_q[k] != '1))
                op_bin_d[k] = op_bin_q[k] + HIST_W'(1);
        end
    end

    always_comb begin
        pacc_sum = pacc_q;
        if (accept)
            pacc_sum = pacc_q + 32'(accesses) + (evtIsAlu ? 32'(ALU_WEIGHT) : 32'd0);
        win_end = (win_q == WW'(PWR_WINDOW - 1));
        win_d   = win_end ? '0 : win_q + WW'(1);
        pacc_d  = win_end ? '0 : pacc_sum;
        pwr_d   = win_end ? sat8(pacc_sum >> PWR_SHIFT) : pwr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset || clear) begin
            instr_q <= '0;
            alu_q   <= '0;
            racc_q  <= '0;
            ovf_q   <= 1'b0;
            win_q   <= '0;
            pacc_q  <= '0;
            pwr_q   <= '0;
            for (int unsigned k = 0; k < NUM_REGS; k++) reg_bin_q[k] <= '0;
            for (int unsigned k = 0; k < NUM_OPS; k++)  op_bin_q[k]  <= '0;
        end else begin
            instr_q <= instr_d[CNT_W-1:0];
            alu_q   <= alu_d[CNT_W-1:0];
            racc_q  <= racc_d[CNT_W-1:0];
            ovf_q   <= ovf_q | wrap;
            win_q   <= win_d;
            pacc_q  <= pacc_d;
            pwr_q   <= pwr_d;
            for (int unsigned k = 0; k < NUM_REGS; k++) reg_bin_q[k] <= reg_bin_d[k];
            for (int unsigned k = 0; k < NUM_OPS; k++)  op_bin_q[k]  <= op_bin_d[k];
        end
    end

    perf_argmax_scan #(
        .NUM_REGS (NUM_REGS),
        .NUM_OPS  (NUM_OPS),
        .HIST_W   (HIST_W)
    ) u_scan (
        .clk_i      (clk),
        .rst_ni     (reset),
        .clear_i    (clear),
        .reg_val_i  (reg_bin_q[scan_idx]),
        .op_val_i   (op_bin_q[scan_idx[OW-1:0]]),
        .idx_o      (scan_idx),
        .best_reg_o (mostUsedReg),
        .best_op_o  (mostUsedOpsALU)
    );

    assign totalInstructions     = instr_q;
    assign totalOperationsALU    = alu_q;
    assign totalRegAccesses      = racc_q;
    assign counterOverflow       = ovf_q;
    assign currentEstimatedPower = pwr_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: three instances (default, narrow counters with
// short window, saturating window) share one stimulus stream.
module tb_perf_monitor;
    import perf_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       evtValid = 1'b0, evtIsAlu = 1'b0, evtUsesRs2 = 1'b0, evtRegWrite = 1'b0;
    logic [3:0] evtOp = '0;
    logic [4:0] evtRs1 = '0, evtRs2 = '0, evtRd = '0;
    logic       clear = 1'b0, freeze = 1'b0;

    logic [31:0] ins0, alu0, acc0;
    logic [4:0]  reg0;
    logic [3:0]  op0;
    logic [7:0]  pwr0;
    logic        ovf0;
    logic [3:0]  ins1, alu1, acc1;
    logic [4:0]  reg1;
    logic [3:0]  op1;
    logic [7:0]  pwr1;
    logic        ovf1;
    logic [31:0] ins2, alu2, acc2;
    logic [4:0]  reg2;
    logic [3:0]  op2;
    logic [7:0]  pwr2;
    logic        ovf2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    perf_monitor u_dut0 (
        .clk(clk), .reset(reset), .evtValid(evtValid), .evtIsAlu(evtIsAlu),
        .evtUsesRs2(evtUsesRs2), .evtRegWrite(evtRegWrite), .evtOp(evtOp),
        .evtRs1(evtRs1), .evtRs2(evtRs2), .evtRd(evtRd), .clear(clear), .freeze(freeze),
        .totalInstructions(ins0), .totalOperationsALU(alu0), .totalRegAccesses(acc0),
        .mostUsedReg(reg0), .mostUsedOpsALU(op0), .currentEstimatedPower(pwr0),
        .counterOverflow(ovf0)
    );

    perf_monitor #(.CNT_W(4), .PWR_WINDOW(8), .PWR_SHIFT(0)) u_dut1 (
        .clk(clk), .reset(reset), .evtValid(evtValid), .evtIsAlu(evtIsAlu),
        .evtUsesRs2(evtUsesRs2), .evtRegWrite(evtRegWrite), .evtOp(evtOp),
        .evtRs1(evtRs1), .evtRs2(evtRs2), .evtRd(evtRd), .clear(clear), .freeze(freeze),
        .totalInstructions(ins1), .totalOperationsALU(alu1), .totalRegAccesses(acc1),
        .mostUsedReg(reg1), .mostUsedOpsALU(op1), .currentEstimatedPower(pwr1),
        .counterOverflow(ovf1)
    );

    perf_monitor #(.PWR_WINDOW(64), .PWR_SHIFT(0)) u_dut2 (
        .clk(clk), .reset(reset), .evtValid(evtValid), .evtIsAlu(evtIsAlu),
        .evtUsesRs2(evtUsesRs2), .evtRegWrite(evtRegWrite), .evtOp(evtOp),
        .evtRs1(evtRs1), .evtRs2(evtRs2), .evtRd(evtRd), .clear(clear), .freeze(freeze),
        .totalInstructions(ins2), .totalOperationsALU(alu2), .totalRegAccesses(acc2),
        .mostUsedReg(reg2), .mostUsedOpsALU(op2), .currentEstimatedPower(pwr2),
        .counterOverflow(ovf2)
    );

    typedef struct packed {
        logic        clr, frz, vld, alu, rs2u, rw;
        logic [3:0]  op;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] e_ins, e_alu, e_acc;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic clr, frz, vld, alu, rs2u, rw,
                                input logic [3:0] op, input logic [4:0] rs1, rs2, rd,
                                input int unsigned ei, ea, ec);
        vec_t v;
        v.clr = clr; v.frz = frz; v.vld = vld; v.alu = alu; v.rs2u = rs2u; v.rw = rw;
        v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.e_ins = ei; v.e_alu = ea; v.e_acc = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic clr, frz, vld, alu, rs2u, rw,
                        input logic [3:0] op, input logic [4:0] rs1, rs2, rd);
        clear = clr; freeze = frz; evtValid = vld; evtIsAlu = alu;
        evtUsesRs2 = rs2u; evtRegWrite = rw; evtOp = op;
        evtRs1 = rs1; evtRs2 = rs2; evtRd = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 4'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic do_clear();
        step(1, 0, 0, 0, 0, 0, 4'd0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        // Totals table: clear-with-event, op0/op1 runs, non-ALU, freeze, idle, rs2 only.
        tbl[0] = mk(1, 0, 1, 1, 1, 1, OP_ADD, 0, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 5; i++)
            tbl[i] = mk(0, 0, 1, 1, 1, 1, OP_ADD, 0, 0, 1, i, i, 3 * i);
        for (int i = 6; i <= 8; i++)
            tbl[i] = mk(0, 0, 1, 1, 1, 1, OP_SUB, 0, 0, 2, i, i, 3 * i);
        tbl[9] = mk(0, 0, 1, 0, 0, 0, OP_ADD, 3, 0, 0, 9, 8, 25);
        for (int i = 10; i <= 13; i++)
            tbl[i] = mk(0, 1, 1, 1, 1, 1, OP_ADD, 5, 5, 5, 9, 8, 25);
        tbl[14] = mk(0, 0, 0, 1, 1, 1, OP_XOR, 6, 6, 6, 9, 8, 25);
        tbl[15] = mk(0, 0, 1, 1, 1, 0, OP_OR, 4, 4, 0, 10, 9, 27);

        repeat (3) @(posedge clk);
        #1;
        check("rst_ins", ins0, 0);
        check("rst_alu", alu0, 0);
        check("rst_acc", acc0, 0);
        check("rst_reg", reg0, 0);
        check("rst_op", op0, 0);
        check("rst_pwr", pwr0, 0);
        check("rst_ovf", ovf0, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].clr, tbl[i].frz, tbl[i].vld, tbl[i].alu, tbl[i].rs2u, tbl[i].rw,
                 tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd);
            check($sformatf("tbl%0d_ins", i), ins0, tbl[i].e_ins);
            check($sformatf("tbl%0d_alu", i), alu0, tbl[i].e_alu);
            check($sformatf("tbl%0d_acc", i), acc0, tbl[i].e_acc);
        end
        idle(66);
        check("argmax_reg_x0", reg0, 0);
        check("argmax_op_0", op0, 0);

        // Tie between op3 and op5; op5 arrives first but lower index must win.
        do_clear();
        step(0, 0, 1, 1, 0, 0, OP_SLL, 7, 0, 0);
        step(0, 0, 1, 1, 0, 0, OP_OR, 7, 0, 0);
        step(0, 0, 1, 1, 0, 0, OP_SLL, 7, 0, 0);
        step(0, 0, 1, 1, 0, 0, OP_OR, 7, 0, 0);
        check("tie_ins", ins0, 4);
        check("tie_acc", acc0, 4);
        idle(66);
        check("tie_op", op0, 3);
        check("tie_reg", reg0, 7);

        do_clear();
        check("clr_ins", ins0, 0);
        check("clr_reg", reg0, 0);
        check("clr_op", op0, 0);

        for (int i = 0; i < 17; i++) step(0, 0, 1, 0, 0, 0, OP_ADD, 0, 0, 0);
        check("wrap_ins", ins1, 1);
        check("wrap_acc", acc1, 1);
        check("wrap_ovf", ovf1, 1);
        check("nowrap_ins", ins0, 17);
        check("nowrap_ovf", ovf0, 0);
        do_clear();
        check("wrapclr_ins", ins1, 0);
        check("wrapclr_ovf", ovf1, 0);

        for (int i = 0; i < 7; i++) step(0, 0, 1, 1, 1, 1, OP_AND, 9, 9, 9);
        check("pwr8_early", pwr1, 0);
        step(0, 0, 1, 1, 1, 1, OP_AND, 9, 9, 9);
        check("pwr8_end", pwr1, 40);
        for (int i = 8; i < 63; i++) step(0, 0, 1, 1, 1, 1, OP_AND, 9, 9, 9);
        check("pwr64_early", pwr2, 0);
        step(0, 0, 1, 1, 1, 1, OP_AND, 9, 9, 9);
        check("pwr64_sat", pwr2, 255);
        check("pwr64_shift2", pwr0, 80);
        check("pwr8_later", pwr1, 40);
        check("pwr_ins", ins0, 64);

        idle(5);
        #3 reset = 1'b0;
        #1;
        check("arst_ins", ins0, 0);
        check("arst_acc", acc0, 0);
        check("arst_pwr", pwr0, 0);
        check("arst_pwr_sat", pwr2, 0);
        check("arst_ovf", ovf1, 0);
        check("arst_reg", reg0, 0);
        check("arst_op", op0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle(66);
        check("post_rst_reg", reg0, 0);
        check("post_rst_op", op0, 0);
        check("post_rst_ins", ins0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 SHALL take parameter CNT_W, 32, width of the total counters.
REQ-002 SHALL take parameter NUM_REGS, 32, register-file size (power of two, >= NUM_OPS).
REQ-003 SHALL take parameter NUM_OPS, 16, number of ALU operation codes tracked (power of two).
REQ-004 SHALL take parameter HIST_W, 16, width of each per-register/per-op histogram bin.
REQ-005 SHALL take parameters PWR_WINDOW (64, cycles per power window), PWR_SHIFT (2, accumulator right-shift) and ALU_WEIGHT (2, power weight per ALU event).
REQ-006 clk input 1: single clock, all logic on rising edge.
REQ-007 reset input 1: asynchronous, active-low reset.
REQ-008 evtValid input 1: one retired instruction this cycle.
REQ-009 evtIsAlu, evtUsesRs2, evtRegWrite input 1 each: event was an ALU op, read rs2, wrote rd.
REQ-010 evtOp input log2(NUM_OPS): ALU op code; evtRs1, evtRs2, evtRd input log2(NUM_REGS): register indices.
REQ-011 clear input 1: synchronous clear of all statistics; freeze input 1: ignore events while high.
REQ-012 totalInstructions, totalOperationsALU, totalRegAccesses output CNT_W: running totals.
REQ-013 mostUsedReg output log2(NUM_REGS), mostUsedOpsALU output log2(NUM_OPS): published argmax indices.
REQ-014 currentEstimatedPower output 8: last completed window power estimate; counterOverflow output 1: sticky total-wrap flag.

Function
REQ-015 Accepted event = evtValid & ~freeze & ~clear; accesses = 1 + evtUsesRs2 + evtRegWrite (1..3).
REQ-016 Per accepted event, the cycle after: totalInstructions +1, totalOperationsALU +evtIsAlu, totalRegAccesses +accesses.
REQ-017 Totals SHALL wrap modulo 2^CNT_W; any wrap sets counterOverflow until clear or reset.
REQ-018 Register bins: rs1 always, rs2 if evtUsesRs2, rd if evtRegWrite; a register named k times in one event adds k; x0 counted like any register.
REQ-019 Op bin evtOp SHALL increment by 1 only when evtIsAlu; all bins saturate at 2^HIST_W-1.
REQ-020 Argmax scan: index sweeps 0..NUM_REGS-1, one bin per cycle, wraps continuously, never stalled by freeze.
REQ-021 Scan compare is strict greater-than against the running max, so the lowest index wins ties; ops compared only for index < NUM_OPS.
REQ-022 At the final index, mostUsedReg/mostUsedOpsALU SHALL update the next cycle and the running max SHALL reset to 0; all-zero bins publish index 0.
REQ-023 Publish latency after a bin change: at most 2*NUM_REGS cycles.
REQ-024 Power accumulator adds ALU_WEIGHT*evtIsAlu + accesses per accepted event; a window counter counts PWR_WINDOW cycles.
REQ-025 At window end currentEstimatedPower = min(255, acc >> PWR_SHIFT), including the final cycle's event; the accumulator restarts at 0.
REQ-026 clear SHALL zero totals, bins, counterOverflow, published indices, power output, scan and window state; clear beats a simultaneous event.

Reset
REQ-027 reset low SHALL immediately zero every output, counter, bin, scan index, running max, window counter and accumulator, including mid-scan or mid-window.
REQ-028 The first window and first scan SHALL begin on the first rising edge after reset deasserts.

Structure
REQ-029 Shared package perf_pkg SHALL hold ALU op-code constants (ADD=0, SUB=1, ...) and default power weights.
REQ-030 The scan SHALL live in one sub-module perf_argmax_scan, instanced once and comparing register and op bins in parallel.

Verification
REQ-031 5 events op 0 then 3 events op 1, all with rs1=x0, rs2=x0, rd=x1/x2, usesRs2=1, regWrite=1, isAlu=1 -> totalInstructions=8, totalOperationsALU=8, totalRegAccesses=24; after 64 cycles mostUsedOpsALU=0, mostUsedReg=0.
REQ-032 Two op-3 and two op-5 ALU events -> mostUsedOpsALU=3 (tie goes to lower index).
REQ-033 CNT_W=4, 17 events -> totalInstructions=1 and counterOverflow=1; then clear -> both 0.
REQ-034 clear and evtValid in the same cycle -> all totals stay 0; freeze=1 with 4 events -> totals unchanged.
REQ-035 PWR_WINDOW=8, PWR_SHIFT=0: 8 ALU events, 3 accesses each -> currentEstimatedPower=40; PWR_WINDOW=64, same events -> 255.
REQ-036 reset asserted mid-scan with nonzero bins -> all outputs 0 in the same cycle; after release with no events, mostUsedReg=0.
